// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a shared-resource multi-cycle MIPS datapath.
// Sequences fetch/decode/execute and drives every mux select and write enable.
module multicycle_ctrl #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Z,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtr,
  output logic       InstDone,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StIf     = 4'd0,
    StId     = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExe    = 4'd6,
    StRwb    = 4'd7,
    StBeq    = 4'd8,
    StJmp    = 4'd9,
    StExi    = 4'd10,
    StIwb    = 4'd11,
    StTrap   = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e     state_q, state_d;
  logic       pc_write, pc_write_cond;
  logic       funct_valid;
  logic [2:0] funct_alu;

  // R-type function decode; unknown functs fall back to add with no writeback.
  always_comb begin
    funct_valid = 1'b1;
    unique case (Funct)
      6'b100000: funct_alu = AluAdd;
      6'b100010: funct_alu = AluSub;
      6'b100100: funct_alu = AluAnd;
      6'b100101: funct_alu = AluOr;
      6'b101010: funct_alu = AluSlt;
      default: begin
        funct_alu   = AluAdd;
        funct_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
        case (Op)
          OpRtype:       state_d = StExe;
          OpLw, OpSw:    state_d = StMemAdr;
          OpBeq:         state_d = StBeq;
          OpJ:           state_d = StJmp;
          OpAddi, OpOri: state_d = StExi;
          default:       state_d = TRAP_ON_ILLEGAL ? StTrap : StIf;
        endcase
      end
      StMemAdr: begin
        if (Op == OpLw) begin
          state_d = StMemRd;
        end else if (Op == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StIf;
        end
      end
      StMemRd: state_d = StMemWb;
      StExe:   state_d = StExe == state_q ? StRwb : StIf;
      StExi:   state_d = StIwb;
      StTrap:  state_d = StTrap;
      default: state_d = StIf;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    PCSrc         = 2'b00;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUCtr        = AluAnd;
    InstDone      = 1'b0;
    Illegal       = 1'b0;
    case (state_q)
      StIf: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        ALUCtr   = AluAdd;
        pc_write = 1'b1;
      end
      StId: begin
        ALUSrcB = 2'b11;
        ALUCtr  = AluAdd;
        case (Op)
          OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi, OpOri: Illegal = 1'b0;
          default:                                        Illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtr  = AluAdd;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        InstDone = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        InstDone = 1'b1;
      end
      StExe: begin
        ALUSrcA = 1'b1;
        ALUCtr  = funct_alu;
      end
      StRwb: begin
        RegWrite = funct_valid;
        RegDst   = 1'b1;
        InstDone = 1'b1;
      end
      StBeq: begin
        ALUSrcA       = 1'b1;
        ALUCtr        = AluSub;
        pc_write_cond = 1'b1;
        PCSrc         = 2'b01;
        InstDone      = 1'b1;
      end
      StJmp: begin
        pc_write = 1'b1;
        PCSrc    = 2'b10;
        InstDone = 1'b1;
      end
      StExi: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUCtr  = (Op == OpOri) ? AluOr : AluAdd;
      end
      StIwb: begin
        RegWrite = 1'b1;
        InstDone = 1'b1;
      end
      default: ;
    endcase
    PCEn = pc_write | (pc_write_cond & Z);
    // Reset kills every side effect in the cycle it is asserted.
    if (Reset) begin
      PCEn     = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      InstDone = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: a cycle model pushes expected control vectors, the
// negedge monitor pops and compares against two DUTs (trap and no-trap).
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Z = 1'b0;

  logic       pcen1, iord1, memread1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1;
  logic       alusrca1, instdone1, illegal1;
  logic [1:0] pcsrc1, alusrcb1;
  logic [2:0] aluctr1;
  logic [3:0] state1;
  logic       pcen0, iord0, memread0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0;
  logic       alusrca0, instdone0, illegal0;
  logic [1:0] pcsrc0, alusrcb0;
  logic [2:0] aluctr0;
  logic [3:0] state0;

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Z(Z),
    .PCEn(pcen1), .PCSrc(pcsrc1), .IorD(iord1), .MemRead(memread1), .MemWrite(memwrite1),
    .IRWrite(irwrite1), .RegDst(regdst1), .MemtoReg(memtoreg1), .RegWrite(regwrite1),
    .ALUSrcA(alusrca1), .ALUSrcB(alusrcb1), .ALUCtr(aluctr1), .InstDone(instdone1),
    .Illegal(illegal1), .State(state1)
  );

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Z(Z),
    .PCEn(pcen0), .PCSrc(pcsrc0), .IorD(iord0), .MemRead(memread0), .MemWrite(memwrite0),
    .IRWrite(irwrite0), .RegDst(regdst0), .MemtoReg(memtoreg0), .RegWrite(regwrite0),
    .ALUSrcA(alusrca0), .ALUSrcB(alusrcb0), .ALUCtr(aluctr0), .InstDone(instdone0),
    .Illegal(illegal0), .State(state0)
  );

  always #5 Clk = ~Clk;

  logic [21:0] vec1, vec0;
  assign vec1 = {state1, pcen1, pcsrc1, iord1, memread1, memwrite1, irwrite1, regdst1,
                 memtoreg1, regwrite1, alusrca1, alusrcb1, aluctr1, instdone1, illegal1};
  assign vec0 = {state0, pcen0, pcsrc0, iord0, memread0, memwrite0, irwrite0, regdst0,
                 memtoreg0, regwrite0, alusrca0, alusrcb0, aluctr0, instdone0, illegal0};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned done_seen = 0;
  int unsigned done_exp = 0;
  logic [21:0] q1[$];
  logic [21:0] q0[$];
  logic [3:0]  s1, s0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for one cycle, written from the control table.
  function automatic logic [21:0] model_out(input logic [3:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z,
                                            input logic rst);
    logic       pcen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, done, ill;
    logic [1:0] psrc, asb;
    logic [2:0] alu;
    {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, done, ill} = '0;
    psrc = 2'b00;
    asb  = 2'b00;
    alu  = 3'b000;
    case (st)
      4'd0: begin mrd = 1; irw = 1; asb = 2'b01; alu = 3'b010; pcen = 1; end
      4'd1: begin
        asb = 2'b11;
        alu = 3'b010;
        ill = !(op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0d});
      end
      4'd2: begin asa = 1; asb = 2'b10; alu = 3'b010; end
      4'd3: begin mrd = 1; iord = 1; end
      4'd4: begin rw = 1; m2r = 1; done = 1; end
      4'd5: begin mwr = 1; iord = 1; done = 1; end
      4'd6: begin
        asa = 1;
        case (fn)
          6'h22:   alu = 3'b110;
          6'h24:   alu = 3'b000;
          6'h25:   alu = 3'b001;
          6'h2a:   alu = 3'b111;
          default: alu = 3'b010;
        endcase
      end
      4'd7: begin
        rw   = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        rdst = 1;
        done = 1;
      end
      4'd8: begin asa = 1; alu = 3'b110; psrc = 2'b01; pcen = z; done = 1; end
      4'd9: begin pcen = 1; psrc = 2'b10; done = 1; end
      4'd10: begin asa = 1; asb = 2'b10; alu = (op == 6'h0d) ? 3'b001 : 3'b010; end
      4'd11: begin rw = 1; done = 1; end
      default: ;
    endcase
    if (rst) {pcen, mwr, rw, irw, mrd, done, ill} = '0;
    return {st, pcen, psrc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, alu, done, ill};
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] st, input logic [5:0] op,
                                            input bit trap);
    case (st)
      4'd0: return 4'd1;
      4'd1: begin
        if (op == 6'h00) return 4'd6;
        if (op == 6'h23 || op == 6'h2b) return 4'd2;
        if (op == 6'h04) return 4'd8;
        if (op == 6'h02) return 4'd9;
        if (op == 6'h08 || op == 6'h0d) return 4'd10;
        return trap ? 4'd15 : 4'd0;
      end
      4'd2: return (op == 6'h23) ? 4'd3 : ((op == 6'h2b) ? 4'd5 : 4'd0);
      4'd3: return 4'd4;
      4'd6: return 4'd7;
      4'd10: return 4'd11;
      4'd15: return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  // One clock: queue expectations, advance the model on the edge.
  task automatic cyc();
    logic [21:0] e;
    e = model_out(s1, Op, Funct, Z, Reset);
    q1.push_back(e);
    if (e[1]) done_exp++;
    q0.push_back(model_out(s0, Op, Funct, Z, Reset));
    @(posedge Clk);
    s1 = Reset ? 4'd0 : model_next(s1, Op, 1'b1);
    s0 = Reset ? 4'd0 : model_next(s0, Op, 1'b0);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n;
    Op = op;
    Funct = fn;
    Z = z;
    n = 0;
    cyc();
    while (s1 != 4'd0 && n < 8) begin
      cyc();
      n++;
    end
  endtask

  always @(negedge Clk) begin
    logic [21:0] e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_eq($sformatf("trap_dut st%0d", e[21:18]), 32'(vec1), 32'(e));
      if (instdone1) done_seen++;
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_eq($sformatf("notrap_dut st%0d", e[21:18]), 32'(vec0), 32'(e));
    end
  end

  logic [5:0] ops[7]  = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0d};
  logic [5:0] fns[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f, 6'h00};

  initial begin
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    s1 = 4'd0;
    s0 = 4'd0;
    cyc();                          // reset state, enables forced low
    Reset = 1'b0;

    // Reset held 3 cycles while sitting in MEMRD of a lw.
    Op = 6'h23;
    Funct = 6'h00;
    Z = 1'b0;
    repeat (3) cyc();
    Reset = 1'b1;
    repeat (3) cyc();
    Reset = 1'b0;
    instr(6'h23, 6'h00, 1'b0);

    instr(6'h00, 6'h22, 1'b0);      // sub
    instr(6'h23, 6'h00, 1'b0);      // lw
    instr(6'h2b, 6'h00, 1'b0);      // sw
    instr(6'h04, 6'h00, 1'b1);      // beq taken
    instr(6'h04, 6'h00, 1'b0);      // beq not taken
    instr(6'h02, 6'h00, 1'b0);      // j
    instr(6'h0d, 6'h00, 1'b0);      // ori
    instr(6'h08, 6'h00, 1'b1);      // addi
    instr(6'h00, 6'h3f, 1'b1);      // bad funct: no writeback, no Illegal

    for (int i = 0; i < 24; i++) begin
      instr(ops[$urandom_range(6)], fns[$urandom_range(6)], 1'($urandom_range(1)));
    end

    // Illegal opcode: trap instance parks, the other keeps fetching.
    Op = 6'h3f;
    Funct = 6'h00;
    Z = 1'b1;
    repeat (6) cyc();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    instr(6'h00, 6'h2a, 1'b0);      // slt after recovery

    @(negedge Clk);
    #1;
    check_eq("instdone_pulses", 32'(done_seen), 32'(done_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared multi-cycle MIPS datapath: one memory, one ALU, PC, IR and ALUOut registers.
- Each instruction is broken into 3–5 states.
- Drives every mux select and write enable, plus the qualified PC enable.
- Sits beside the datapath. Op/Funct come from the IR; Z comes from the ALU.

Parameters:
- TRAP_ON_ILLEGAL, 1: 1 = an illegal opcode parks the FSM in TRAP until reset; 0 = an illegal opcode returns to IF and fetches the next instruction.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Z  in  1  ALU zero flag (current cycle)
- PCEn  out  1  PC load = PCWrite | (PCWriteCond & Z)
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump {PC[31:28],IR[25:0],00}
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR load enable
- RegDst  out  1  write register: 0 rt, 1 rd
- MemtoReg  out  1  write data: 0 ALUOut, 1 MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0 PC, 1 A-reg
- ALUSrcB  out  2  ALU B input: 00 B-reg, 01 const 4, 10 sext imm, 11 sext imm<<2
- ALUCtr  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- InstDone  out  1  1-cycle pulse in the final state of each instruction
- Illegal  out  1  high for one cycle in ID when the opcode is undecodable
- State  out  4  current state code (debug)

Behaviour:
- State codes: IF=0, ID=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXE=6, RWB=7, BEQ=8, JMP=9, EXI=10, IWB=11, TRAP=15.
- Unused codes go to IF on the next edge.
- Reset:
  - State<=IF on the edge.
  - While Reset=1, all outputs are forced to 0: PCEn, MemWrite, RegWrite, IRWrite, MemRead, InstDone, Illegal.
  - Reset asserted mid-instruction abandons that instruction; no partial write occurs after the edge.
- Outputs are decoded from State only. Exception: PCEn also uses Z in BEQ. Signals not listed below are 0.
- IF:
  - MemRead=1, IorD=0, IRWrite=1.
  - ALUSrcA=0, ALUSrcB=01, ALUCtr=add, PCSrc=00, PCWrite=1.
  - Next: ID.
- ID:
  - ALUSrcA=0, ALUSrcB=11, ALUCtr=add, producing the branch target in ALUOut.
  - Next state by Op:
    - 000000 (R-type) → EXE
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000100 (beq) → BEQ
    - 000010 (j) → JMP
    - 001000 (addi) or 001101 (ori) → EXI
    - other → Illegal=1; next state TRAP if TRAP_ON_ILLEGAL=1, else IF.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1. Next: MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, InstDone=1. Next: IF.
- MEMWR: MemWrite=1, IorD=1, InstDone=1. Next: IF.
- EXE: ALUSrcA=1, ALUSrcB=00. ALUCtr by Funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other Funct: ALUCtr=add, and RWB suppresses RegWrite. No Illegal pulse in this case.
  - Next: RWB.
- RWB: RegWrite=1 (when Funct is valid), RegDst=1, MemtoReg=0, InstDone=1. Next: IF.
- BEQ:
  - ALUSrcA=1, ALUSrcB=00, ALUCtr=sub, PCWriteCond=1, PCSrc=01.
  - PCEn=Z, combinational in this cycle.
  - InstDone=1. Next: IF.
- JMP: PCWrite=1, PCSrc=10, InstDone=1. Next: IF.
- EXI: ALUSrcA=1, ALUSrcB=10, ALUCtr = add for addi, or for ori. Next: IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, InstDone=1. Next: IF.
- TRAP: all enables 0, Illegal=0. Stays in TRAP until Reset.
- Op and Funct are sampled only in ID, EXE, EXI, MEMADR and RWB. The IR is stable because IRWrite is asserted only in IF.
- Cycle counts (IF through last state): R 4, lw 5, sw 4, beq 3, j 3, addi/ori 4. InstDone pulses exactly once per instruction.

Test Plan:
- Reset held 3 cycles mid-lw (State=MEMRD) → State=IF after the first edge; MemRead=0, PCEn=0, InstDone=0 while Reset=1; first IF cycle after release has PCEn=1, IRWrite=1.
- Op=000000, Funct=100010 → States 0,1,6,7; ALUCtr=110 in EXE; RegWrite=1, RegDst=1 in RWB; InstDone high only in RWB.
- Op=100011 then Op=101011 → States 0,1,2,3,4 (MemtoReg=1, RegWrite=1), then 0,1,2,5 (MemWrite=1, IorD=1); 9 cycles total.
- Op=000100 with Z=1, then again with Z=0 → BEQ state gives PCEn=1, PCSrc=01 in the first case and PCEn=0 in the second; each instruction takes 3 cycles.
- Op=000010, then Op=001101 → JMP gives PCEn=1, PCSrc=10; ori gives ALUCtr=001 in EXI and RegWrite=1, RegDst=0 in IWB.
- Op=111111 with TRAP_ON_ILLEGAL=1 → Illegal=1 for one cycle in ID, then State=15 with all enables held at 0 until Reset. With TRAP_ON_ILLEGAL=0 → Illegal pulse, then State=IF.
